// File: rtl/obj_locate_pkg.sv
// Shared types for the per-frame object locator: FSM states, bounding box record,
// the "no object" marker and the centre/pack helper.
package obj_locate_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        EMIT     = 2'd2
    } state_t;

    // Coordinates are carried zero-extended to 16 bits so the packed word layout is fixed.
    typedef struct packed {
        logic [15:0] xmin;
        logic [15:0] xmax;
        logic [15:0] ymin;
        logic [15:0] ymax;
    } bbox_t;

    localparam logic [31:0] NO_OBJ = 32'hFFFF_FFFF;

    // Box centre packed as {cy, cx}; the 17-bit sums cannot overflow.
    function automatic logic [31:0] loc_pack(input bbox_t b);
        logic [16:0] sx;
        logic [16:0] sy;
        sx = {1'b0, b.xmin} + {1'b0, b.xmax};
        sy = {1'b0, b.ymin} + {1'b0, b.ymax};
        return {sy[16:1], sx[16:1]};
    endfunction

endpackage

// File: rtl/obj_bbox_acc.sv
// Bounding-box and hot-pixel accumulator. Optional OBJ_MIN_PIX_EN keeps a 32-bit
// saturating hot count checked against MIN_PIX; otherwise a single "any hot" flag.
module obj_bbox_acc
    import obj_locate_pkg::*;
#(
    parameter int COORD_W = 16
`ifdef OBJ_MIN_PIX_EN
    ,
    parameter int MIN_PIX = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               hot,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output bbox_t              bbox,
    output logic               obj_valid
);

    logic [15:0] xv;
    logic [15:0] yv;
    logic        have;
    logic        load;

    assign xv = 16'(x);
    assign yv = 16'(y);

`ifdef OBJ_MIN_PIX_EN
    logic [31:0] npix;

    always_ff @(posedge clk) begin
        if (rst) begin
            npix <= '0;
        end else if (init) begin
            npix <= {31'd0, hot};
        end else if (hot && (npix != '1)) begin
            npix <= npix + 32'd1;
        end
    end

    assign have      = (npix != '0);
    assign obj_valid = (npix >= 32'(MIN_PIX));
`else
    logic any_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            any_hot <= 1'b0;
        end else if (init) begin
            any_hot <= hot;
        end else if (hot) begin
            any_hot <= 1'b1;
        end
    end

    assign have      = any_hot;
    assign obj_valid = any_hot;
`endif

    // The first hot pixel of a frame loads the box outright instead of min/max merging.
    assign load = hot && (init || !have);

    always_ff @(posedge clk) begin
        if (rst) begin
            bbox <= '0;
        end else if (load) begin
            bbox <= '{xmin: xv, xmax: xv, ymin: yv, ymax: yv};
        end else if (hot) begin
            if (xv < bbox.xmin) bbox.xmin <= xv;
            if (xv > bbox.xmax) bbox.xmax <= xv;
            if (yv < bbox.ymin) bbox.ymin <= yv;
            if (yv > bbox.ymax) bbox.ymax <= yv;
        end else if (init) begin
            bbox <= '0;
        end
    end

endmodule

// File: rtl/obj_centroid.sv
// Per-frame object locator: thresholds an AXI4-Stream frame, emits {cy, cx} of the hot-pixel
// bounding box centre or NO_OBJ. Build option OBJ_MIN_PIX_EN enables the MIN_PIX count check.
module obj_centroid
    import obj_locate_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 16,
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 720,
    parameter int MIN_PIX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] thresh,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    if (COORD_W < 1 || COORD_W > 16 || MIN_PIX < 1 ||
        IMG_W > (1 << COORD_W) || IMG_H > (1 << COORD_W)) begin : g_bad_cfg
        $error("obj_centroid: unsupported parameter set");
    end

    // Handshakes: a beat moves on a rising clk edge where valid && ready are both high;
    // valid never waits on ready, and an offered output word is held until taken.
    state_t             state;
    state_t             state_nx;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [PIX_W-1:0]   thresh_q;
    logic [PIX_W-1:0]   thr_eff;
    logic               accept;
    logic               sof;
    logic               in_frame;
    logic               hot;
    logic               eof;
    bbox_t              bbox;
    logic               obj_valid;

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign sof      = accept && s_axis_tuser;
    assign in_frame = sof || (accept && (state == ACCUM));

    // A start-of-frame beat is pixel (0,0) and is judged against the threshold arriving with it.
    assign cur_x    = sof ? '0 : x_q;
    assign cur_y    = sof ? '0 : y_q;
    assign thr_eff  = s_axis_tuser ? thresh : thresh_q;
    assign hot      = in_frame && (s_axis_tdata >= thr_eff);
    assign eof      = in_frame && s_axis_tlast && (cur_y == COORD_W'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            thresh_q <= '0;
        end else begin
            if (sof) thresh_q <= thresh;
            if (in_frame) begin
                if (s_axis_tlast) begin
                    x_q <= '0;
                    y_q <= cur_y + 1'b1;
                end else begin
                    x_q <= (cur_x == COORD_W'(IMG_W - 1)) ? cur_x : cur_x + 1'b1;
                    y_q <= cur_y;
                end
            end
        end
    end

    obj_bbox_acc #(
        .COORD_W (COORD_W)
`ifdef OBJ_MIN_PIX_EN
        ,
        .MIN_PIX (MIN_PIX)
`endif
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .init      (sof),
        .hot       (hot),
        .x         (cur_x),
        .y         (cur_y),
        .bbox      (bbox),
        .obj_valid (obj_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_SOF: begin
                if (eof) begin
                    state_nx = EMIT;
                end else if (sof) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (eof) state_nx = EMIT;
            end
            EMIT: begin
                if (m_axis_tready) state_nx = WAIT_SOF;
            end
            default: state_nx = WAIT_SOF;
        endcase
    end

    // The box is frozen during EMIT because no input beat is accepted there.
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        if (state == EMIT) begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = obj_valid ? loc_pack(bbox) : NO_OBJ;
        end
    end

endmodule

// File: tb/tb_obj_centroid.sv
// Directed bench for obj_centroid on an 8x4 image: centre words, stall hold, empty frames,
// pre-SOF junk, aborted frames, reset during emit, threshold latching and back-to-back frames.
module tb_obj_centroid;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 16;
    localparam int W       = 8;
    localparam int H       = 4;
    localparam int MIN_PIX = 4;
    localparam logic [31:0] NO_OBJ_W = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic [PIX_W-1:0] thresh;
    logic [PIX_W-1:0] s_axis_tdata;
    logic             s_axis_tuser;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;

    int total = 0;
    int bad   = 0;

    logic [31:0]      exp_q[$];
    logic [31:0]      recv_q[$];
    logic [PIX_W-1:0] img[0:H-1][0:W-1];

    always #5 clk = ~clk;

    obj_centroid #(
        .PIX_W   (PIX_W),
        .COORD_W (COORD_W),
        .IMG_W   (W),
        .IMG_H   (H),
        .MIN_PIX (MIN_PIX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .thresh        (thresh),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // Output monitor: every completed output handshake lands in recv_q.
    always @(posedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) recv_q.push_back(m_axis_tdata);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        foreach (img[yy, xx]) img[yy][xx] = '0;
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
    endtask

    task automatic beat(input logic [PIX_W-1:0] d, input logic u, input logic l);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 100) begin
            tick();
            n++;
        end
        if (!s_axis_tready) chk1("beat_wait_tready", s_axis_tready, 1'b1);
        tick();
    endtask

    // Sends rows 0..nrows-1 of img; thresh switches to thr2 just before row chg_row.
    task automatic send_frame(input int nrows, input int chg_row, input logic [PIX_W-1:0] thr2);
        for (int yy = 0; yy < nrows; yy++) begin
            if (yy == chg_row) thresh = thr2;
            for (int xx = 0; xx < W; xx++) begin
                beat(img[yy][xx], (yy == 0 && xx == 0), (xx == W - 1));
            end
        end
    endtask

    task automatic get_word(input string tag, input logic [31:0] expv);
        int n;
        n = 0;
        exp_q.push_back(expv);
        m_axis_tready = 1'b1;
        while (recv_q.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        m_axis_tready = 1'b0;
        if (recv_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(recv_q.size()), 32'd1);
            void'(exp_q.pop_front());
        end else begin
            chk(tag, recv_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        rst           = 1'b1;
        thresh        = '0;
        m_axis_tready = 1'b0;
        idle();
        clear_img();
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk1("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk ("rst_m_tdata", m_axis_tdata, 32'h0);
        chk1("rst_s_tready", s_axis_tready, 1'b1);

        // 1: single hot pixel at (3,2), latency and bubble
        clear_img();
        img[2][3] = 8'd200;
        thresh = 8'd128;
        send_frame(H, -1, 8'd0);
        idle();
        chk1("t1_tvalid_n1", m_axis_tvalid, 1'b1);
        chk1("t1_sready_n1", s_axis_tready, 1'b0);
        chk ("t1_tdata_n1", m_axis_tdata, 32'h0002_0003);
        get_word("t1_word", 32'h0002_0003);
        chk1("t1_tvalid_n2", m_axis_tvalid, 1'b0);
        chk1("t1_sready_n2", s_axis_tready, 1'b1);

        // 2: hot at (1,1) and (6,3) (128 == thresh counts), held under back-pressure
        clear_img();
        img[1][1] = 8'd255;
        img[3][6] = 8'd128;
        send_frame(H, -1, 8'd0);
        idle();
        for (int i = 0; i < 5; i++) begin
            chk ("t2_hold_tdata", m_axis_tdata, 32'h0002_0003);
            chk1("t2_hold_tvalid", m_axis_tvalid, 1'b1);
            chk1("t2_hold_sready", s_axis_tready, 1'b0);
            tick();
        end
        get_word("t2_word", 32'h0002_0003);

        // 3: empty frame, then 3 and 4 hot pixels (127 just below thresh is cold)
        clear_img();
        img[1][2] = 8'd127;
        send_frame(H, -1, 8'd0);
        idle();
        get_word("t3_empty", NO_OBJ_W);
        img[0][0] = 8'd200;
        img[0][7] = 8'd200;
        img[3][0] = 8'd200;
        send_frame(H, -1, 8'd0);
        idle();
`ifdef OBJ_MIN_PIX_EN
        get_word("t3_three_hot", NO_OBJ_W);
`else
        get_word("t3_three_hot", 32'h0001_0003);
`endif
        img[3][7] = 8'd200;
        send_frame(H, -1, 8'd0);
        idle();
        get_word("t3_four_hot", 32'h0001_0003);

        // 4: junk before SOF, aborted frame, then a clean frame
        beat(8'd255, 1'b0, 1'b0);
        beat(8'd255, 1'b0, 1'b1);
        beat(8'd255, 1'b0, 1'b0);
        idle();
        chk1("t4_junk_no_word", m_axis_tvalid, 1'b0);
        clear_img();
        img[0][7] = 8'd255;
        img[1][7] = 8'd255;
        send_frame(2, -1, 8'd0);
        chk1("t4_abort_no_word", m_axis_tvalid, 1'b0);
        clear_img();
        img[3][2] = 8'd255;
        send_frame(H, -1, 8'd0);
        idle();
        chk1("t4_tvalid", m_axis_tvalid, 1'b1);
        get_word("t4_word", 32'h0003_0002);

        // 5: reset while emitting drops the word
        clear_img();
        img[1][1] = 8'd200;
        send_frame(H, -1, 8'd0);
        idle();
        chk1("t5_emit", m_axis_tvalid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("t5_rst_tvalid", m_axis_tvalid, 1'b0);
        chk1("t5_rst_sready", s_axis_tready, 1'b1);
        chk ("t5_rst_tdata", m_axis_tdata, 32'h0);
        m_axis_tready = 1'b1;
        repeat (3) tick();
        m_axis_tready = 1'b0;
        chk("t5_no_stale", 32'(recv_q.size()), 32'd0);
        clear_img();
        img[1][4] = 8'd200;
        send_frame(H, -1, 8'd0);
        idle();
        get_word("t5_after_rst", 32'h0001_0004);

        // 6: thresh raised mid-frame has no effect until next SOF
        clear_img();
        img[0][1] = 8'd150;
        img[2][5] = 8'd150;
        thresh = 8'd100;
        send_frame(H, 1, 8'd250);
        idle();
        get_word("t6_thresh_latched", 32'h0001_0003);

        // 6: back-to-back frames with tready held high
        thresh = 8'd128;
        clear_img();
        img[1][2] = 8'd200;
        m_axis_tready = 1'b1;
        send_frame(H, -1, 8'd0);
        chk1("t6_b2b_tvalid_n1", m_axis_tvalid, 1'b1);
        chk1("t6_b2b_sready_n1", s_axis_tready, 1'b0);
        tick();
        chk1("t6_b2b_tvalid_n2", m_axis_tvalid, 1'b0);
        chk1("t6_b2b_sready_n2", s_axis_tready, 1'b1);
        clear_img();
        img[3][7] = 8'd200;
        send_frame(H, -1, 8'd0);
        idle();
        tick();
        m_axis_tready = 1'b0;
        chk("t6_b2b_count", 32'(recv_q.size()), 32'd2);
        if (recv_q.size() >= 2) begin
            chk("t6_b2b_first", recv_q.pop_front(), 32'h0001_0002);
            chk("t6_b2b_second", recv_q.pop_front(), 32'h0003_0007);
        end
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
